// File: rtl/memory_access_pkg.sv
// Shared encodings for the memory stage: funct3 access codes, result-select
// value for loads, FSM states and access-size decode.
package memory_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULTSRC_MEM = 2'b01;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Any funct3 that is not a byte or half access is treated as a full word.
    function automatic size_e access_size(input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data replication / byte enables and
// load byte/half extraction with sign or zero extension.
module mem_lane_align
    import memory_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            st_funct3_i,
    input  logic [1:0]            st_addr_lo_i,
    input  logic [DATA_WIDTH-1:0] st_data_i,
    output logic [DATA_WIDTH-1:0] st_wdata_o,
    output logic [3:0]            st_be_o,
    input  logic [2:0]            ld_funct3_i,
    input  logic [1:0]            ld_addr_lo_i,
    input  logic [DATA_WIDTH-1:0] ld_rdata_i,
    output logic [DATA_WIDTH-1:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sext;

    always_comb begin
        st_wdata_o = st_data_i;
        st_be_o    = 4'b1111;
        case (access_size(st_funct3_i))
            SZ_B: begin
                st_be_o    = 4'b0001 << st_addr_lo_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Half select ignores addr[0], which forces misaligned halves aligned.
    always_comb begin
        ld_byte   = 8'(ld_rdata_i >> {ld_addr_lo_i, 3'b000});
        ld_half   = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
        ld_sext   = (ld_funct3_i != F3_BU) && (ld_funct3_i != F3_HU);
        ld_data_o = ld_rdata_i;
        case (access_size(ld_funct3_i))
            SZ_B:    ld_data_o = {{24{ld_sext & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data_o = {{16{ld_sext & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: issues data-memory req/ack accesses, stalls while one
// is outstanding and registers the E bundle. MEM_MISALIGN_TRAP_EN adds MisalignE.
//
// state  | meaning
// IDLE   | no access outstanding; non-memory ops pass through in one cycle
// ACCESS | bus request held until DMemAck; E loads on the ack edge
module memory_access
    import memory_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  MemWriteD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [4:0]            RdD,
    input  logic [DATA_WIDTH-1:0] MemWriteDataD,
    input  logic [DATA_WIDTH-1:0] ALUResultD,
    input  logic [2:0]            Funct3D,
    output logic [DATA_WIDTH-1:0] ForwardALUResultDH,
    output logic                  StallM,
    output logic                  DMemReq,
    output logic                  DMemWe,
    output logic [DATA_WIDTH-1:0] DMemAddr,
    output logic [DATA_WIDTH-1:0] DMemWData,
    output logic [3:0]            DMemBe,
    input  logic [DATA_WIDTH-1:0] DMemRData,
    input  logic                  DMemAck,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic [4:0]            RdE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [DATA_WIDTH-1:0] ALUResultE,
    output logic [DATA_WIDTH-1:0] ReadDataE
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  MisalignE
`endif
);

    state_e state_q, state_d;

    logic memop, misalign, start;
    logic stall, bus_load, e_load, e_bubble, ack_done;

    logic                  req_q, we_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q;
    logic [3:0]            be_q;
    logic [2:0]            f3_q;
    logic [1:0]            alo_q;

    logic                  regwrite_q;
    logic [1:0]            resultsrc_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] pcplus4_q, aluresult_q, readdata_q;

    logic [DATA_WIDTH-1:0] st_wdata, ld_data;
    logic [3:0]            st_be;

    assign memop = MemWriteD | (ResultSrcD == RESULTSRC_MEM);

`ifdef MEM_MISALIGN_TRAP_EN
    size_e d_size;
    logic  misalign_q;

    assign d_size   = access_size(Funct3D);
    assign misalign = memop & (((d_size == SZ_H) & ALUResultD[0]) |
                               ((d_size == SZ_W) & (|ALUResultD[1:0])));
    assign MisalignE = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= e_load & misalign;
    end
`else
    assign misalign = 1'b0;
`endif

    assign start = memop & ~misalign;

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .st_funct3_i  (Funct3D),
        .st_addr_lo_i (ALUResultD[1:0]),
        .st_data_i    (MemWriteDataD),
        .st_wdata_o   (st_wdata),
        .st_be_o      (st_be),
        .ld_funct3_i  (f3_q),
        .ld_addr_lo_i (alo_q),
        .ld_rdata_i   (DMemRData),
        .ld_data_o    (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = ACCESS;
            ACCESS:  if (DMemAck) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        bus_load = 1'b0;
        e_load   = 1'b0;
        e_bubble = 1'b0;
        ack_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall    = 1'b1;
                    bus_load = 1'b1;
                    e_bubble = 1'b1;
                end else begin
                    e_load = 1'b1;
                end
            end
            ACCESS: begin
                if (DMemAck) begin
                    e_load   = 1'b1;
                    ack_done = 1'b1;
                end else begin
                    stall    = 1'b1;
                    e_bubble = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Gate with reset so the hazard unit sees the stall drop with no edge.
    assign StallM             = stall & rst_n;
    assign ForwardALUResultDH = ALUResultD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            alo_q   <= '0;
        end else if (bus_load) begin
            req_q   <= 1'b1;
            we_q    <= MemWriteD;
            addr_q  <= {ALUResultD[DATA_WIDTH-1:2], 2'b00};
            wdata_q <= st_wdata;
            be_q    <= st_be;
            f3_q    <= Funct3D;
            alo_q   <= ALUResultD[1:0];
        end else if (ack_done) begin
            req_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= '0;
            rd_q        <= '0;
            pcplus4_q   <= '0;
            aluresult_q <= '0;
            readdata_q  <= '0;
        end else if (e_load) begin
            regwrite_q  <= RegWriteD & ~misalign;
            resultsrc_q <= ResultSrcD;
            rd_q        <= RdD;
            pcplus4_q   <= PCPlus4D;
            aluresult_q <= ALUResultD;
            readdata_q  <= (ack_done & ~we_q) ? ld_data : '0;
        end else if (e_bubble) begin
            regwrite_q <= 1'b0;
        end
    end

    assign DMemReq    = req_q;
    assign DMemWe     = we_q;
    assign DMemAddr   = addr_q;
    assign DMemWData  = wdata_q;
    assign DMemBe     = be_q;
    assign RegWriteE  = regwrite_q;
    assign ResultSrcE = resultsrc_q;
    assign RdE        = rd_q;
    assign PCPlus4E   = pcplus4_q;
    assign ALUResultE = aluresult_q;
    assign ReadDataE  = readdata_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: ALU pass-through, store lanes, load
// extension, wait-state stalls, async reset mid-access, optional misalign trap.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteD, MemWriteD, DMemAck;
    logic [1:0]  ResultSrcD;
    logic [4:0]  RdD;
    logic [2:0]  Funct3D;
    logic [31:0] PCPlus4D, MemWriteDataD, ALUResultD, DMemRData;
    logic [31:0] ForwardALUResultDH, DMemAddr, DMemWData, PCPlus4E, ALUResultE, ReadDataE;
    logic        StallM, DMemReq, DMemWe, RegWriteE;
    logic [3:0]  DMemBe;
    logic [1:0]  ResultSrcE;
    logic [4:0]  RdE;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MisalignE;
`endif

    int total = 0;
    int bad   = 0;
    int stalls, bubbles;
    logic        done;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    always #5 clk = ~clk;

    memory_access #(.DATA_WIDTH(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .RegWriteD          (RegWriteD),
        .ResultSrcD         (ResultSrcD),
        .MemWriteD          (MemWriteD),
        .PCPlus4D           (PCPlus4D),
        .RdD                (RdD),
        .MemWriteDataD      (MemWriteDataD),
        .ALUResultD         (ALUResultD),
        .Funct3D            (Funct3D),
        .ForwardALUResultDH (ForwardALUResultDH),
        .StallM             (StallM),
        .DMemReq            (DMemReq),
        .DMemWe             (DMemWe),
        .DMemAddr           (DMemAddr),
        .DMemWData          (DMemWData),
        .DMemBe             (DMemBe),
        .DMemRData          (DMemRData),
        .DMemAck            (DMemAck),
        .RegWriteE          (RegWriteE),
        .ResultSrcE         (ResultSrcE),
        .RdE                (RdE),
        .PCPlus4E           (PCPlus4E),
        .ALUResultE         (ALUResultE),
        .ReadDataE          (ReadDataE)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .MisalignE          (MisalignE)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        RegWriteD     = rw;
        ResultSrcD    = rs;
        MemWriteD     = mw;
        Funct3D       = f3;
        ALUResultD    = addr;
        MemWriteDataD = wd;
        RdD           = rd;
        PCPlus4D      = 32'h400 + {27'd0, rd};
    endtask

    // Called 1 time unit after a rising edge with the memop already driven.
    task automatic run_access(input int waits, input logic [31:0] rdata);
        int   n;
        logic acked;
        n = 0; stalls = 0; bubbles = 0; done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            acked = 1'b0;
            if (DMemReq) begin
                if (n == waits) begin
                    DMemAck   = 1'b1;
                    DMemRData = rdata;
                    acked     = 1'b1;
                    cap_addr  = DMemAddr;
                    cap_wdata = DMemWData;
                    cap_be    = DMemBe;
                    cap_we    = DMemWe;
                end else begin
                    n++;
                end
            end
            #1;
            if (StallM) stalls++;
            @(posedge clk); #1;
            DMemAck   = 1'b0;
            DMemRData = '0;
            if (acked) done = 1'b1;
            else if (RegWriteE === 1'b0) bubbles++;
        end
        chk("access_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; DMemAck = 1'b0; DMemRData = '0;
        drive(0, 2'b00, 0, 3'd0, 32'd0, 32'd0, 5'd0);
        #3;
        chk("rst_req",    {31'd0, DMemReq},   32'd0);
        chk("rst_stall",  {31'd0, StallM},    32'd0);
        chk("rst_regwr",  {31'd0, RegWriteE}, 32'd0);
        chk("rst_alu",    ALUResultE,         32'd0);
        chk("rst_rdata",  ReadDataE,          32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU op passes straight through
        drive(1, 2'b00, 0, 3'd0, 32'd150, 32'd0, 5'd3);
        #1;
        chk("fwd",        ForwardALUResultDH, 32'd150);
        chk("alu_stall0", {31'd0, StallM},    32'd0);
        @(posedge clk); #1;
        chk("alu_regwr",  {31'd0, RegWriteE}, 32'd1);
        chk("alu_res",    ALUResultE,         32'd150);
        chk("alu_rd",     {27'd0, RdE},       32'd3);
        chk("alu_pc",     PCPlus4E,           32'h403);
        chk("alu_stall1", {31'd0, StallM},    32'd0);

        // SB at 0x1003
        drive(0, 2'b00, 1, 3'd0, 32'h1003, 32'h0000_00AB, 5'd5);
        run_access(0, 32'd0);
        chk("sb_stalls", stalls,             32'd1);
        chk("sb_addr",   cap_addr,           32'h1000);
        chk("sb_be",     {28'd0, cap_be},    32'h8);
        chk("sb_wdata",  cap_wdata,          32'hABAB_ABAB);
        chk("sb_we",     {31'd0, cap_we},    32'd1);
        chk("sb_rdata",  ReadDataE,          32'd0);
        chk("sb_reqoff", {31'd0, DMemReq},   32'd0);
        chk("sb_rd",     {27'd0, RdE},       32'd5);

        // SH at 0x1002, one wait state
        drive(0, 2'b00, 1, 3'd1, 32'h1002, 32'h0000_1234, 5'd0);
        run_access(1, 32'd0);
        chk("sh_stalls", stalls,          32'd2);
        chk("sh_be",     {28'd0, cap_be}, 32'hC);
        chk("sh_wdata",  cap_wdata,       32'h1234_1234);

        // SW at misaligned 0x1001 is forced to the word
        drive(0, 2'b00, 1, 3'd2, 32'h1001, 32'hDEAD_BEEF, 5'd0);
        run_access(0, 32'd0);
        chk("sw_addr",   cap_addr,        32'h1000);
        chk("sw_be",     {28'd0, cap_be}, 32'hF);
        chk("sw_wdata",  cap_wdata,       32'hDEAD_BEEF);

        // LB / LBU at 0x2001 with three wait states
        drive(1, 2'b01, 0, 3'd0, 32'h2001, 32'd0, 5'd7);
        run_access(3, 32'h0000_8000);
        chk("lb_stalls",  stalls,              32'd4);
        chk("lb_bubbles", bubbles,             32'd4);
        chk("lb_data",    ReadDataE,           32'hFFFF_FF80);
        chk("lb_regwr",   {31'd0, RegWriteE},  32'd1);
        chk("lb_rd",      {27'd0, RdE},        32'd7);
        chk("lb_rsrc",    {30'd0, ResultSrcE}, 32'd1);
        chk("lb_we",      {31'd0, cap_we},     32'd0);
        chk("lb_addr",    cap_addr,            32'h2000);
        chk("lb_alu",     ALUResultE,          32'h2001);
        drive(1, 2'b01, 0, 3'd4, 32'h2001, 32'd0, 5'd7);
        run_access(3, 32'h0000_8000);
        chk("lbu_data",   ReadDataE,           32'h0000_0080);
        chk("lbu_stalls", stalls,              32'd4);

        // Halfword and word loads at 0x2002
        drive(1, 2'b01, 0, 3'd1, 32'h2002, 32'd0, 5'd8);
        run_access(0, 32'h8001_0000);
        chk("lh_data",  ReadDataE, 32'hFFFF_8001);
        drive(1, 2'b01, 0, 3'd5, 32'h2002, 32'd0, 5'd8);
        run_access(0, 32'h8001_0000);
        chk("lhu_data", ReadDataE, 32'h0000_8001);
        drive(1, 2'b01, 0, 3'd2, 32'h2002, 32'd0, 5'd8);
        run_access(2, 32'h8001_0000);
        chk("lw_data",  ReadDataE, 32'h8001_0000);

        // ALU op right after a load clears ReadDataE
        drive(1, 2'b00, 0, 3'd0, 32'h55, 32'd0, 5'd9);
        @(posedge clk); #1;
        chk("post_rdata", ReadDataE,          32'd0);
        chk("post_alu",   ALUResultE,         32'h55);
        chk("post_regwr", {31'd0, RegWriteE}, 32'd1);

        // Async reset while an access is outstanding
        drive(1, 2'b01, 0, 3'd2, 32'h2004, 32'd0, 5'd4);
        @(posedge clk); #1;
        chk("ra_req1",   {31'd0, DMemReq}, 32'd1);
        chk("ra_stall1", {31'd0, StallM},  32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_req0",   {31'd0, DMemReq},   32'd0);
        chk("ra_stall0", {31'd0, StallM},    32'd0);
        chk("ra_regwr",  {31'd0, RegWriteE}, 32'd0);
        chk("ra_alu",    ALUResultE,         32'd0);
        drive(0, 2'b00, 0, 3'd0, 32'd0, 32'd0, 5'd0);
        DMemAck = 1'b1; DMemRData = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("ra_rdata_a", ReadDataE, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ra_rdata_b", ReadDataE,        32'd0);
        chk("ra_req_b",   {31'd0, DMemReq}, 32'd0);
        chk("ra_stall_b", {31'd0, StallM},  32'd0);
        DMemAck = 1'b0; DMemRData = '0;

        // Normal access after reset
        drive(1, 2'b01, 0, 3'd2, 32'h2008, 32'd0, 5'd6);
        run_access(0, 32'h1357_9BDF);
        chk("ar_data",   ReadDataE, 32'h1357_9BDF);
        chk("ar_stalls", stalls,    32'd1);

`ifdef MEM_MISALIGN_TRAP_EN
        drive(1, 2'b01, 0, 3'd2, 32'h3002, 32'd0, 5'd2);
        #1;
        chk("mis_stall", {31'd0, StallM}, 32'd0);
        @(posedge clk); #1;
        chk("mis_req",   {31'd0, DMemReq},   32'd0);
        chk("mis_flag",  {31'd0, MisalignE}, 32'd1);
        chk("mis_regwr", {31'd0, RegWriteE}, 32'd0);
        drive(0, 2'b00, 0, 3'd0, 32'd0, 32'd0, 5'd0);
        @(posedge clk); #1;
        chk("mis_flag0", {31'd0, MisalignE}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the 5-stage RISC-V pipeline.
- Consumes the D-stage bundle from the execute stage and performs data-memory loads and stores over a req/ack bus.
- Byte, half and word accesses, selected by Funct3D; loaded data is sign- or zero-extended.
- Registers results into the E (writeback) stage, stalls the pipe while an access is outstanding, and feeds the ALU result back to the forwarding mux.

Parameters:
- DATA_WIDTH, 32, datapath/address width; only 32 supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- RegWriteD  in  1  register write enable from execute
- ResultSrcD  in  2  result select; 2'b01 = load
- MemWriteD  in  1  store request
- PCPlus4D  in  DATA_WIDTH  PC+4 passthrough
- RdD  in  5  destination register
- MemWriteDataD  in  DATA_WIDTH  store data (unaligned, low bits)
- ALUResultD  in  DATA_WIDTH  ALU result / effective address
- Funct3D  in  3  access size/sign
- ForwardALUResultDH  out  DATA_WIDTH  combinational copy of ALUResultD to the execute forward mux
- StallM  out  1  hazard-unit stall; upstream holds D inputs stable while high
- DMemReq  out  1  bus request (registered)
- DMemWe  out  1  1 = write
- DMemAddr  out  DATA_WIDTH  word address {addr[31:2],2'b00}
- DMemWData  out  DATA_WIDTH  lane-replicated store data
- DMemBe  out  4  byte enables
- DMemRData  in  DATA_WIDTH  read data, valid with ack
- DMemAck  in  1  access complete
- RegWriteE, ResultSrcE[2], RdE[5], PCPlus4E, ALUResultE, ReadDataE  out  E-stage register outputs

Behaviour:
- Reset (async, rst_n low):
  - All outputs and registered state clear to 0 immediately; FSM goes to IDLE.
  - DMemReq drops at once; an ack arriving after reset is ignored.
- memop = MemWriteD | (ResultSrcD==2'b01).
- FSM IDLE:
  - memop=0: E registers load the D bundle each cycle; latency 1.
  - memop=1: StallM=1 combinationally. Next edge enters ACCESS and registers DMemReq=1, DMemWe=MemWriteD, DMemAddr, DMemWData, DMemBe.
  - The E register loads a bubble: RegWriteE=0, other E fields hold.
- FSM ACCESS:
  - DMemReq and all bus fields are held stable until DMemAck.
  - StallM = ~DMemAck.
  - On an ack edge:
    - E loads the D bundle; ReadDataE = extended DMemRData for loads, 0 for stores.
    - DMemReq <= 0; FSM returns to IDLE.
  - Minimum memop latency is 2 cycles (ack in the first ACCESS cycle).
  - A memop presented in the cycle after an ack re-enters ACCESS; there is one IDLE cycle between accesses.
- Store lanes (a = ALUResultD[1:0]):
  - SB (f3=0): Be = 4'b0001<<a; WData = {4{byte}}.
  - SH (f3=1): Be = a[1] ? 1100 : 0011; WData = {2{half}}.
  - SW (f3=2) and f3 = 3, 6, 7: Be=1111; WData unmodified.
- Load extract, using the registered address low bits:
  - LB (0) sign-extends the selected byte; LBU (4) zero-extends it.
  - LH (1) sign-extends the half selected by a[1]; LHU (5) zero-extends it.
  - LW (2) and f3 = 3, 6, 7: full word.
- Misaligned addresses (feature off): the low bits beyond the access size are ignored, i.e. the access is forced aligned.
- DMemAck outside ACCESS is ignored.
- Funct3D is not registered to E; it is consumed here.

Optional Feature:
- MEM_MISALIGN_TRAP_EN
- Defined:
  - Adds output MisalignE (1 bit, reset 0).
  - A halfword memop with a[0]=1, or a word memop with a[1:0]!=0, issues no bus request and causes no stall.
  - E loads with RegWriteE=0 and MisalignE=1 for one cycle.
- Undefined: the port is absent and the forced-align behaviour above applies.

Decomposition:
- Shared package: funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), RESULTSRC_MEM=2'b01, FSM state enum {IDLE, ACCESS}.
- Sub-module mem_lane_align:
  - Combinational store lane/Be generation and load extract/extension.
  - Reused by the future load/store unit.

Test Plan:
- ALU op (RegWriteD=1, ResultSrcD=00, ALUResultD=150, RdD=3) -> next edge RegWriteE=1, ALUResultE=150, RdE=3; StallM never high; ForwardALUResultDH=150 in the same cycle.
- SB at ALUResultD=0x1003, MemWriteDataD=0xAB, ack in the first ACCESS cycle -> DMemAddr=0x1000, DMemBe=1000, DMemWData=0xABABABAB, DMemWe=1; StallM high exactly 1 cycle.
- LB/LBU at addr 0x2001, DMemRData=0x0000_8000, ack after 3 wait cycles -> StallM high 4 cycles; ReadDataE=0xFFFF_FF80 for LB, 0x0000_0080 for LBU; one bubble (RegWriteE=0) per stalled cycle.
- LH at addr 0x2002, RData=0x8001_0000 -> 0xFFFF_8001; LHU -> 0x0000_8001; LW -> 0x8001_0000.
- rst_n deasserted while in ACCESS with DMemReq=1 -> DMemReq=0 and StallM=0 with no clock edge; a later DMemAck pulse produces no E update.
- MEM_MISALIGN_TRAP_EN defined, LW at 0x3002 -> DMemReq stays 0, MisalignE=1 for one cycle, RegWriteE=0.
